// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port SRAM between instruction fetch (read-only)
// and the MEM-stage data port (read/write, byte-enabled). Accesses are
// serialised: each one is held on the memory port for MEM_LAT cycles, and then
// the owning requester gets a one-cycle ack with its read data.
// A data port that keeps requesting can take at most STARVE_LIM grants in a
// row while fetch waits; after that, fetch is served.
// Ports:
//   clk, rst                          clock, async active-low reset
//   if_req/if_addr/if_flush           fetch request, address, branch cancel
//   if_ack/if_rdata/if_stall          fetch completion, instruction, stall
//   dm_req/dm_addr/dm_w_en/dm_wdata   data request (w_en == 0 means read)
//   dm_ack/dm_rdata/dm_stall          data completion, load data, stall
//   mem_en/mem_addr/mem_w_en/mem_wdata/mem_rdata  SRAM port
module mem_arbiter #(
  parameter int unsigned MEM_LAT    = 2,
  parameter int unsigned STARVE_LIM = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  input  logic        if_flush,
  output logic        if_ack,
  output logic [31:0] if_rdata,
  output logic        if_stall,
  input  logic        dm_req,
  input  logic [31:0] dm_addr,
  input  logic [3:0]  dm_w_en,
  input  logic [31:0] dm_wdata,
  output logic        dm_ack,
  output logic [31:0] dm_rdata,
  output logic        dm_stall,
  output logic        mem_en,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_w_en,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam int unsigned STK_W = (STARVE_LIM > 0) ? $clog2(STARVE_LIM + 1) : 1;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;
  typedef enum logic {OWN_IF, OWN_DM} owner_t;

  state_t             r_state, w_state_nxt;
  owner_t             r_owner, w_owner_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic [STK_W-1:0]   r_streak, w_streak_nxt;
  logic               r_cancel, w_cancel_nxt;
  logic [31:0]        r_addr, w_addr_nxt;
  logic [3:0]         r_w_en, w_w_en_nxt;
  logic [31:0]        r_wdata, w_wdata_nxt;
  logic [31:0]        r_if_resp, w_if_resp_nxt;
  logic [31:0]        r_if_rdata, w_if_rdata_nxt;
  logic [31:0]        r_dm_rdata, w_dm_rdata_nxt;

  logic w_busy, w_resp, w_grant_dm, w_grant_if, w_if_live;

  assign w_busy = (r_state == S_BUSY);
  assign w_resp = (r_state == S_RESP);

  // DM wins ties unless fetch has already waited out STARVE_LIM data grants.
  assign w_grant_dm = dm_req & (~if_req | (r_streak != STK_W'(STARVE_LIM)));
  assign w_grant_if = if_req & ~w_grant_dm;

  // A fetch response is delivered only if no flush arrived during its access,
  // including a flush in the response cycle itself.
  assign w_if_live = w_resp & (r_owner == OWN_IF) & ~r_cancel & ~if_flush;

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_owner    <= OWN_IF;
      r_cnt      <= '0;
      r_streak   <= '0;
      r_cancel   <= 1'b0;
      r_addr     <= '0;
      r_w_en     <= '0;
      r_wdata    <= '0;
      r_if_resp  <= '0;
      r_if_rdata <= '0;
      r_dm_rdata <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_owner    <= w_owner_nxt;
      r_cnt      <= w_cnt_nxt;
      r_streak   <= w_streak_nxt;
      r_cancel   <= w_cancel_nxt;
      r_addr     <= w_addr_nxt;
      r_w_en     <= w_w_en_nxt;
      r_wdata    <= w_wdata_nxt;
      r_if_resp  <= w_if_resp_nxt;
      r_if_rdata <= w_if_rdata_nxt;
      r_dm_rdata <= w_dm_rdata_nxt;
    end
  end

  // Next-state, arbitration and response capture.
  always_comb begin
    w_state_nxt    = r_state;
    w_owner_nxt    = r_owner;
    w_cnt_nxt      = r_cnt;
    w_streak_nxt   = r_streak;
    w_cancel_nxt   = r_cancel;
    w_addr_nxt     = r_addr;
    w_w_en_nxt     = r_w_en;
    w_wdata_nxt    = r_wdata;
    w_if_resp_nxt  = r_if_resp;
    w_if_rdata_nxt = r_if_rdata;
    w_dm_rdata_nxt = r_dm_rdata;
    case (r_state)
      S_IDLE: begin
        w_cancel_nxt = 1'b0;
        if (w_grant_dm) begin
          w_state_nxt = S_BUSY;
          w_owner_nxt = OWN_DM;
          w_cnt_nxt   = CNT_W'(MEM_LAT - 1);
          w_addr_nxt  = dm_addr;
          w_w_en_nxt  = dm_w_en;
          w_wdata_nxt = dm_wdata;
          if (!if_req) begin
            w_streak_nxt = '0;
          end else if (r_streak != STK_W'(STARVE_LIM)) begin
            w_streak_nxt = r_streak + STK_W'(1);
          end
        end else if (w_grant_if) begin
          w_state_nxt  = S_BUSY;
          w_owner_nxt  = OWN_IF;
          w_cnt_nxt    = CNT_W'(MEM_LAT - 1);
          w_addr_nxt   = if_addr;
          w_w_en_nxt   = '0;
          w_wdata_nxt  = '0;
          w_streak_nxt = '0;
        end
      end
      S_BUSY: begin
        if ((r_owner == OWN_IF) && if_flush) begin
          w_cancel_nxt = 1'b1;
        end
        if (r_cnt == '0) begin
          w_state_nxt = S_RESP;
          if (r_owner == OWN_IF) begin
            w_if_resp_nxt = mem_rdata;
          end else if (r_w_en == '0) begin
            w_dm_rdata_nxt = mem_rdata;
          end
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      S_RESP: begin
        w_state_nxt  = S_IDLE;
        w_cancel_nxt = 1'b0;
        if (w_if_live) begin
          w_if_rdata_nxt = r_if_resp;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Memory port is driven only while an access is held.
  assign mem_en    = w_busy;
  assign mem_addr  = w_busy ? r_addr  : '0;
  assign mem_w_en  = w_busy ? r_w_en  : '0;
  assign mem_wdata = w_busy ? r_wdata : '0;

  // Fresh fetch data is shown in the ack cycle, the committed word otherwise.
  assign if_ack   = w_if_live;
  assign if_rdata = w_if_live ? r_if_resp : r_if_rdata;
  assign dm_ack   = w_resp & (r_owner == OWN_DM);
  assign dm_rdata = r_dm_rdata;

  // Stalls are forced low while reset is asserted.
  assign if_stall = rst & if_req & ~if_ack;
  assign dm_stall = rst & dm_req & ~dm_ack;

endmodule
